// File: rtl/vnarrow_wb_merge.sv
// rtl/vnarrow_wb_merge.sv - merges narrowed half-word writes and queues them for the VRF write port
//
// Purpose:
//   Sits between the narrowing ALU stage and the VRF write port. The narrowing
//   stage writes each 64-bit destination word in two partial beats, one per
//   half, and both beats carry the same address. This block combines the
//   complementary beats in a merge register (M). It then queues the combined
//   writes in a small first-word-fall-through FIFO that has a valid/ready
//   handshake. Upstream cannot be stalled, so a push into a full FIFO is
//   dropped and recorded in a sticky overflow flag.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_vec     narrowed data beat from upstream
//   in_be      byte enables of in_vec
//   in_addr    destination word address
//   in_valid   input beat valid (no backpressure)
//   in_flush   end of instruction; force the held partial entry out
//   out_vec    write data at FIFO head
//   out_be     write byte enables at FIFO head
//   out_addr   write address at FIFO head
//   out_valid  FIFO non-empty
//   out_ready  VRF accepts the head entry when out_valid && out_ready
//   busy       merge register valid, FIFO non-empty or flush pending
//   overflow   sticky: a push was dropped because the FIFO was full

module vnarrow_wb_merge #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 32,
   parameter int BE_WIDTH     = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_vec,
   input  logic [BE_WIDTH-1:0]   in_be,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic                  in_valid,
   input  logic                  in_flush,
   output logic [DATA_WIDTH-1:0] out_vec,
   output logic [BE_WIDTH-1:0]   out_be,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  overflow
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // merge register
   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic [BE_WIDTH-1:0]     m_be_q, m_be_d;
   logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
   logic [IDLE_W-1:0]       idle_q, idle_d;
   logic                    pend_q, pend_d;

   // output FIFO
   logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
   logic [BE_WIDTH-1:0]     fifo_be_q   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    overflow_q, overflow_d;

   // push request from the merge logic toward the FIFO
   logic                    push;
   logic [DATA_WIDTH-1:0]   push_data;
   logic [BE_WIDTH-1:0]     push_be;
   logic [ADDR_WIDTH-1:0]   push_addr;

   logic [DATA_WIDTH-1:0]   in_mask;
   logic [DATA_WIDTH-1:0]   merged_data;
   logic [BE_WIDTH-1:0]     merged_be;
   logic                    beat;
   logic                    addr_match;
   logic                    overlap;
   logic                    eff_hold;
   logic                    fifo_full;
   logic                    pop;
   logic                    accept;

   // Byte-wise combine: each byte comes from the input where its enable is
   // set, otherwise from M. Masked input is used when M is loaded, so that
   // disabled lanes never carry stale upstream data into a later merge.
   always_comb begin
      in_mask     = '0;
      merged_data = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
         in_mask[i*8 +: 8]     = {8{in_be[i]}};
         merged_data[i*8 +: 8] = in_be[i] ? in_vec[i*8 +: 8] : m_data_q[i*8 +: 8];
      end
      merged_be = in_be | m_be_q;
   end

   assign beat       = in_valid && (in_be != '0);
   assign addr_match = (in_addr == m_addr_q);
   assign overlap    = (in_be & m_be_q) != '0;
   // A pending flush empties M in this cycle, so a new beat sees EMPTY.
   assign eff_hold   = (state_q == HOLD) && !pend_q;

   always_comb begin
      state_d   = state_q;
      m_data_d  = m_data_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      push      = 1'b0;
      push_data = m_data_q;
      push_be   = m_be_q;
      push_addr = m_addr_q;

      // The pending flush takes the push slot. Any beat this cycle is then
      // processed as from EMPTY, and that path never pushes.
      if (pend_q && (state_q == HOLD)) begin
         push    = 1'b1;
         state_d = EMPTY;
      end

      if (in_valid) begin
         if (beat) begin
            if (!eff_hold) begin
               state_d  = HOLD;
               m_data_d = in_vec & in_mask;
               m_be_d   = in_be;
               m_addr_d = in_addr;
            end else if (addr_match && !overlap) begin
               if (&merged_be) begin
                  push      = 1'b1;
                  push_data = merged_data;
                  push_be   = merged_be;
                  state_d   = EMPTY;
               end else begin
                  m_data_d = merged_data;
                  m_be_d   = merged_be;
               end
            end else begin
               // The beat conflicts with M. Retire M unchanged and start a
               // new entry from the beat.
               push     = 1'b1;
               state_d  = HOLD;
               m_data_d = in_vec & in_mask;
               m_be_d   = in_be;
               m_addr_d = in_addr;
            end
         end
      end else if (eff_hold) begin
         if (in_flush || (idle_q == IDLE_LAST)) begin
            push    = 1'b1;
            state_d = EMPTY;
         end
      end

      idle_d = (in_valid || (state_d == EMPTY)) ? '0 : idle_q + IDLE_W'(1);
      pend_d = in_valid && in_flush;
   end

   // FIFO control. A push into a full FIFO succeeds only if the head is
   // popped at the same edge. M still advances when a push is dropped.
   assign fifo_full = (count_q == CNT_FULL);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign accept    = push && (!fifo_full || pop);

   always_comb begin
      wr_ptr_d   = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
      overflow_d = overflow_q || (push && fifo_full && !pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         m_data_q   <= '0;
         m_be_q     <= '0;
         m_addr_q   <= '0;
         idle_q     <= '0;
         pend_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_be_q[i]   <= '0;
            fifo_addr_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         m_data_q   <= m_data_d;
         m_be_q     <= m_be_d;
         m_addr_q   <= m_addr_d;
         idle_q     <= idle_d;
         pend_q     <= pend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         if (accept) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_be_q[wr_ptr_q]   <= push_be;
            fifo_addr_q[wr_ptr_q] <= push_addr;
         end
      end
   end

   assign out_vec  = fifo_data_q[rd_ptr_q];
   assign out_be   = fifo_be_q[rd_ptr_q];
   assign out_addr = fifo_addr_q[rd_ptr_q];
   assign busy     = (state_q == HOLD) || out_valid || pend_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_vnarrow_wb_merge.sv
// tb/tb_vnarrow_wb_merge.sv - directed-vector bench for vnarrow_wb_merge

module tb_vnarrow_wb_merge;

   logic        clk;
   logic        rst;
   logic [63:0] in_vec;
   logic [7:0]  in_be;
   logic [31:0] in_addr;
   logic        in_valid;
   logic        in_flush;
   logic [63:0] out_vec;
   logic [7:0]  out_be;
   logic [31:0] out_addr;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        overflow;

   int total;
   int passes;

   vnarrow_wb_merge dut (
      .clk       (clk),
      .rst       (rst),
      .in_vec    (in_vec),
      .in_be     (in_be),
      .in_addr   (in_addr),
      .in_valid  (in_valid),
      .in_flush  (in_flush),
      .out_vec   (out_vec),
      .out_be    (out_be),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        f;
      logic [7:0]  be;
      logic [31:0] addr;
      logic [63:0] vec;
      logic        rdy;
      logic        ev;
      logic [7:0]  ebe;
      logic [31:0] eaddr;
      logic [63:0] evec;
      logic        ebusy;
   } row_t;

   row_t tbl[$];

   task automatic add(input logic v, input logic f, input logic [7:0] be,
                      input logic [31:0] addr, input logic [63:0] vec,
                      input logic ev, input logic [7:0] ebe, input logic [31:0] eaddr,
                      input logic [63:0] evec, input logic ebusy);
      row_t r;
      r.v = v; r.f = f; r.be = be; r.addr = addr; r.vec = vec; r.rdy = 1'b1;
      r.ev = ev; r.ebe = ebe; r.eaddr = eaddr; r.evec = evec; r.ebusy = ebusy;
      tbl.push_back(r);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // one cycle: drive at the falling edge, sample 1 time unit after the rising edge
   task automatic beat(input logic v, input logic f, input logic [7:0] be,
                       input logic [31:0] addr, input logic [63:0] vec, input logic rdy);
      @(negedge clk);
      in_valid = v; in_flush = f; in_be = be; in_addr = addr; in_vec = vec; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // full-word merge whose result is {addr, addr}; rdy2 applies on the second beat
   task automatic merge_pair(input logic [31:0] addr, input logic rdy1, input logic rdy2);
      beat(1'b1, 1'b0, 8'h0F, addr, {32'h0, addr}, rdy1);
      beat(1'b1, 1'b0, 8'hF0, addr, {addr, 32'h0}, rdy2);
   endtask

   task automatic idle(input logic rdy);
      beat(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, rdy);
   endtask

   task automatic drain(input string tag, input logic [31:0] base, input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         chk($sformatf("%s head%0d valid", tag, k), {63'h0, out_valid}, 64'h1);
         chk($sformatf("%s head%0d addr", tag, k), {32'h0, out_addr}, {32'h0, base + 32'(k)});
         chk($sformatf("%s head%0d vec", tag, k), out_vec, {base + 32'(k), base + 32'(k)});
         idle(1'b1);
      end
      chk($sformatf("%s drained", tag), {63'h0, out_valid}, 64'h0);
   endtask

   initial begin
      total = 0;
      passes = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_flush = 1'b0; in_be = '0; in_addr = '0; in_vec = '0; out_ready = 1'b1;

      // reset state
      #3;
      chk("reset out_valid", {63'h0, out_valid}, 64'h0);
      chk("reset busy", {63'h0, busy}, 64'h0);
      chk("reset overflow", {63'h0, overflow}, 64'h0);
      chk("reset out_vec", out_vec, 64'h0);
      chk("reset out_be", {56'h0, out_be}, 64'h0);
      chk("reset out_addr", {32'h0, out_addr}, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      //   v  f  be     addr        vec                    ev ebe    eaddr       evec                   busy
      add(1, 0, 8'h0F, 32'h10, 64'h00000000_AABBCCDD, 0, 8'h00, 32'h00, 64'h0, 1);
      add(1, 0, 8'hF0, 32'h10, 64'h11223344_00000000, 1, 8'hFF, 32'h10, 64'h11223344_AABBCCDD, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);
      add(1, 0, 8'h0F, 32'h10, 64'h00000000_01020304, 0, 8'h00, 32'h00, 64'h0, 1);
      add(1, 0, 8'h0F, 32'h11, 64'h00000000_05060708, 1, 8'h0F, 32'h10, 64'h00000000_01020304, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 1, 8'h0F, 32'h11, 64'h00000000_05060708, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);
      add(1, 1, 8'h0F, 32'h20, 64'h00000000_0A0B0C0D, 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 1, 8'h0F, 32'h20, 64'h00000000_0A0B0C0D, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);
      add(1, 0, 8'hF0, 32'h30, 64'h99887766_00000000, 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 1, 8'h00, 32'h00, 64'h0,                 1, 8'hF0, 32'h30, 64'h99887766_00000000, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);
      add(1, 0, 8'hF0, 32'h40, 64'hDEADBEEF_00000000, 0, 8'h00, 32'h00, 64'h0, 1);
      add(1, 0, 8'h0F, 32'h40, 64'h00000000_12345678, 1, 8'hFF, 32'h40, 64'hDEADBEEF_12345678, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);
      add(1, 0, 8'h03, 32'h50, 64'h00000000_00001111, 0, 8'h00, 32'h00, 64'h0, 1);
      add(1, 0, 8'h06, 32'h50, 64'h00000000_00002200, 1, 8'h03, 32'h50, 64'h00000000_00001111, 1);
      add(1, 0, 8'h09, 32'h50, 64'h00000000_44000033, 0, 8'h00, 32'h00, 64'h0, 1);
      add(1, 0, 8'h00, 32'h50, 64'hFFFFFFFF_FFFFFFFF, 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 1, 8'h00, 32'h00, 64'h0,                 1, 8'h0F, 32'h50, 64'h00000000_44002233, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);
      add(1, 1, 8'h0F, 32'h60, 64'h00000000_00000001, 0, 8'h00, 32'h00, 64'h0, 1);
      add(1, 0, 8'hF0, 32'h60, 64'h00000002_00000000, 1, 8'h0F, 32'h60, 64'h00000000_00000001, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 1);
      add(0, 1, 8'h00, 32'h00, 64'h0,                 1, 8'hF0, 32'h60, 64'h00000002_00000000, 1);
      add(0, 0, 8'h00, 32'h00, 64'h0,                 0, 8'h00, 32'h00, 64'h0, 0);

      foreach (tbl[i]) begin
         beat(tbl[i].v, tbl[i].f, tbl[i].be, tbl[i].addr, tbl[i].vec, tbl[i].rdy);
         chk($sformatf("row%0d out_valid", i), {63'h0, out_valid}, {63'h0, tbl[i].ev});
         chk($sformatf("row%0d busy", i), {63'h0, busy}, {63'h0, tbl[i].ebusy});
         chk($sformatf("row%0d overflow", i), {63'h0, overflow}, 64'h0);
         if (tbl[i].ev) begin
            chk($sformatf("row%0d out_addr", i), {32'h0, out_addr}, {32'h0, tbl[i].eaddr});
            chk($sformatf("row%0d out_be", i), {56'h0, out_be}, {56'h0, tbl[i].ebe});
            chk($sformatf("row%0d out_vec", i), out_vec, tbl[i].evec);
         end
      end

      // full FIFO with a same-cycle push and pop
      for (int k = 0; k < 4; k++) merge_pair(32'h100 + 32'(k), 1'b0, 1'b0);
      chk("full head addr", {32'h0, out_addr}, 64'h100);
      chk("full overflow", {63'h0, overflow}, 64'h0);
      merge_pair(32'h104, 1'b0, 1'b1);
      chk("pushpop overflow", {63'h0, overflow}, 64'h0);
      drain("pushpop", 32'h100, 1, 4);
      chk("pushpop busy", {63'h0, busy}, 64'h0);
      chk("pushpop overflow end", {63'h0, overflow}, 64'h0);

      // overflow: fifth push into a full FIFO is dropped
      for (int k = 0; k < 4; k++) merge_pair(32'h200 + 32'(k), 1'b0, 1'b0);
      chk("ovf before", {63'h0, overflow}, 64'h0);
      merge_pair(32'h204, 1'b0, 1'b0);
      chk("ovf set", {63'h0, overflow}, 64'h1);
      drain("ovf", 32'h200, 0, 4);
      chk("ovf sticky", {63'h0, overflow}, 64'h1);

      // asynchronous reset while M holds a half and the FIFO has two entries
      merge_pair(32'h300, 1'b0, 1'b0);
      merge_pair(32'h301, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 8'h0F, 32'h302, 64'h0, 1'b0);
      chk("prerst out_valid", {63'h0, out_valid}, 64'h1);
      chk("prerst busy", {63'h0, busy}, 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", {63'h0, out_valid}, 64'h0);
      chk("async rst busy", {63'h0, busy}, 64'h0);
      chk("async rst overflow", {63'h0, overflow}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      merge_pair(32'h310, 1'b1, 1'b1);
      chk("postrst out_valid", {63'h0, out_valid}, 64'h1);
      chk("postrst out_addr", {32'h0, out_addr}, 64'h310);
      chk("postrst out_be", {56'h0, out_be}, 64'hFF);
      chk("postrst out_vec", out_vec, {32'h310, 32'h310});
      idle(1'b1);
      chk("postrst busy", {63'h0, busy}, 64'h0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
